led_matrix_scan_driver: RTL and testbench

Parametrised successor to the game's in-line display logic: a double-buffered row-scan driver for a ROWS×COLS multi-colour LED matrix plus a DIGITS-wide multiplexed 7-segment BCD display. Game logic writes pixel rows into a back buffer and requests a swap. The driver commits swaps only at frame boundaries, so no torn frames are shown. It adds per-row blanking for ghost suppression and leading-zero suppression, and replaces the per-design hand-coded scan loops.

---
 rtl/led_matrix_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver
//   Double-buffered row-scan driver for a ROWS x COLS multi-plane LED matrix,
//   plus a DIGITS-wide multiplexed 7-segment BCD display.
//   Game logic writes rows into the back buffer and requests a swap. Swaps are
//   committed only on the row-wrap edge, so a frame is never torn.
//
// Ports
//   CLK          system clock
//   reset        asynchronous, active-low reset
//   wr_en        write strobe into the back buffer
//   wr_row       row to write (ignored when >= ROWS)
//   wr_plane     colour plane to write (ignored when >= PLANES)
//   wr_data      pixel bits, 1 = lit, bit c = column c
//   swap_req     level request to exchange back/front at the next frame start
//   swap_ack     one-cycle pulse on the edge the swap takes effect
//   frame_start  one-cycle pulse when row_sel wraps to 0
//   row_sel      row currently driven
//   col_n        active-low columns, bit p*COLS+c = plane p, column c
//   bcd_in       score digits, nibble d = digit d (digit 0 = ones)
//   seg_n        active-low segments {a,b,c,d,e,f,g}
//   com_n        active-low one-hot digit enables
module led_matrix_scan_driver #(
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8,
   parameter int unsigned PLANES    = 3,
   parameter int unsigned ROW_W     = 3,
   parameter int unsigned SCAN_DIV  = 25000,
   parameter int unsigned BLANK_CYC = 1,
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned DIG_DIV   = 50000,
   parameter int unsigned LZS       = 1
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ROW_W-1:0]         wr_row,
   input  logic [1:0]               wr_plane,
   input  logic [COLS-1:0]          wr_data,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     frame_start,
   output logic [ROW_W-1:0]         row_sel,
   output logic [PLANES*COLS-1:0]   col_n,
   input  logic [4*DIGITS-1:0]      bcd_in,
   output logic [6:0]               seg_n,
   output logic [DIGITS-1:0]        com_n
);

   localparam int unsigned RW  = PLANES * COLS;
   localparam int unsigned DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned RIW = (ROWS > 1)     ? $clog2(ROWS)     : 1;
   localparam int unsigned PIW = (PLANES > 1)   ? $clog2(PLANES)   : 1;
   localparam int unsigned DDW = (DIG_DIV > 1)  ? $clog2(DIG_DIV)  : 1;
   localparam int unsigned DGW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

   localparam logic [DW-1:0]    DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW:0]      BLANK_L    = (DW+1)'(BLANK_CYC);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W:0]   ROWS_L     = (ROW_W+1)'(ROWS);
   localparam logic [2:0]       PLANES_L   = 3'(PLANES);
   localparam logic [DDW-1:0]   DIV_LAST   = DDW'(DIG_DIV - 1);
   localparam logic [DGW-1:0]   DIG_LAST   = DGW'(DIGITS - 1);

   // ------------------------------------------------------------------
   // Frame buffers: one word per row holding all planes, laid out exactly
   // as col_n expects (plane p at bits p*COLS +: COLS).
   // ------------------------------------------------------------------
   logic [RW-1:0]    fb [2][ROWS];
   logic             front;
   logic [DW-1:0]    dwell;

   logic             row_end, wrap, do_swap, wr_ok, nxt_front;
   logic [DW-1:0]    nxt_dwell;
   logic [ROW_W-1:0] nxt_row;
   logic [RIW-1:0]   wr_row_i, nxt_row_i;
   logic [PIW-1:0]   wr_plane_i;
   int unsigned      wr_base;
   logic [RW-1:0]    nxt_row_data;

   always_comb begin
      row_end    = (dwell == DWELL_LAST);
      wrap       = row_end && (row_sel == ROW_LAST);
      do_swap    = wrap && swap_req;
      nxt_front  = front ^ do_swap;
      nxt_dwell  = row_end ? '0 : dwell + 1'b1;
      nxt_row    = row_sel;
      if (row_end)
         nxt_row = (row_sel == ROW_LAST) ? '0 : row_sel + 1'b1;
      wr_ok      = wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_plane} < PLANES_L);
      wr_row_i   = wr_row[RIW-1:0];
      wr_plane_i = wr_plane[PIW-1:0];
      wr_base    = 32'(wr_plane_i) * COLS;
      nxt_row_i  = nxt_row[RIW-1:0];
   end

   // Row shown after this edge. A write landing in the old back buffer on the
   // swap edge is forwarded so it is visible at once, even with no blanking.
   always_comb begin
      nxt_row_data = fb[nxt_front][nxt_row_i];
      if (wr_ok && (nxt_front != front) && (wr_row_i == nxt_row_i))
         nxt_row_data[wr_base +: COLS] = wr_data;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         dwell       <= '0;
         row_sel     <= '0;
         front       <= 1'b0;
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
         col_n       <= '1;
         for (int unsigned r = 0; r < ROWS; r++) begin
            fb[0][r] <= '0;
            fb[1][r] <= '0;
         end
      end else begin
         dwell       <= nxt_dwell;
         row_sel     <= nxt_row;
         front       <= nxt_front;
         frame_start <= wrap;
         swap_ack    <= do_swap;
         col_n       <= ({1'b0, nxt_dwell} < BLANK_L) ? '1 : ~nxt_row_data;
         // Write targets the pre-swap back buffer.
         if (wr_ok)
            fb[~front][wr_row_i][wr_base +: COLS] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // 7-segment multiplexer
   // ------------------------------------------------------------------
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [DDW-1:0] div_cnt;
   logic [DGW-1:0] dig, nxt_dig;
   logic           dig_step, nxt_lz, nxt_blank;
   int unsigned    nd;
   logic [3:0]     nxt_nib;
   logic [6:0]     nxt_seg;

   always_comb begin
      dig_step = (div_cnt == DIV_LAST);
      nxt_dig  = (dig == DIG_LAST) ? '0 : dig + 1'b1;
      nd       = 32'(nxt_dig);
      nxt_nib  = bcd_in[4*nd +: 4];
      // Leading zero: this digit and every more significant one are zero.
      nxt_lz   = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++)
         if ((k >= nd) && (bcd_in[4*k +: 4] != 4'd0))
            nxt_lz = 1'b0;
      nxt_blank = (LZS != 0) && (nxt_dig != '0) && nxt_lz;
      nxt_seg   = nxt_blank ? 7'b1111111 : seg_decode(nxt_nib);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         dig     <= '0;
         seg_n   <= 7'b1111111;
         com_n   <= ~DIGITS'(1);
      end else if (dig_step) begin
         div_cnt <= '0;
         dig     <= nxt_dig;
         seg_n   <= nxt_seg;
         com_n   <= ~(DIGITS'(1) << nxt_dig);
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
module tb_led_matrix_scan_driver;

   localparam int ROWS = 4, COLS = 4, PLANES = 3, ROW_W = 3, SCAN_DIV = 4;
   localparam int BLANK_CYC = 1, DIGITS = 4, DIG_DIV = 2, LZS = 1;
   localparam int RW = PLANES * COLS;
   localparam int FRAME = ROWS * SCAN_DIV;

   logic                 CLK = 1'b0;
   logic                 reset;
   logic                 wr_en;
   logic [ROW_W-1:0]     wr_row;
   logic [1:0]           wr_plane;
   logic [COLS-1:0]      wr_data;
   logic                 swap_req;
   logic                 swap_ack;
   logic                 frame_start;
   logic [ROW_W-1:0]     row_sel;
   logic [RW-1:0]        col_n;
   logic [4*DIGITS-1:0]  bcd_in;
   logic [6:0]           seg_n;
   logic [DIGITS-1:0]    com_n;

   led_matrix_scan_driver #(
      .ROWS(ROWS), .COLS(COLS), .PLANES(PLANES), .ROW_W(ROW_W),
      .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .DIGITS(DIGITS),
      .DIG_DIV(DIG_DIV), .LZS(LZS)
   ) dut (
      .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
      .wr_plane(wr_plane), .wr_data(wr_data), .swap_req(swap_req),
      .swap_ack(swap_ack), .frame_start(frame_start), .row_sel(row_sel),
      .col_n(col_n), .bcd_in(bcd_in), .seg_n(seg_n), .com_n(com_n)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [ROW_W-1:0]  row;
      logic [RW-1:0]     col;
      logic              fs;
      logic              ack;
      logic [6:0]        seg;
      logic [DIGITS-1:0] com;
   } exp_t;

   exp_t q[$];

   logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

   logic [COLS-1:0] mbuf [2][ROWS][PLANES];
   int              t;
   int              mfront;
   logic [6:0]      mseg;

   function automatic logic [6:0] model_seg(input logic [15:0] bcd, input int d);
      int upper = int'(bcd) >> (4 * d);
      int nib   = upper % 16;
      if (d > 0 && upper == 0) return 7'h7F;
      if (nib > 9) return 7'h7F;
      return segtab[nib];
   endfunction

   always @(posedge CLK) begin
      exp_t e;
      int   dwell, row;
      bit   wrap, ack;
      wrap = 0;
      ack  = 0;
      if (!reset) begin
         t = 0;
         mfront = 0;
         mseg = 7'h7F;
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
               for (int p = 0; p < PLANES; p++) mbuf[b][r][p] = '0;
      end else begin
         t++;
         wrap = (t % FRAME) == 0;
         if (wr_en && int'(wr_row) < ROWS && int'(wr_plane) < PLANES)
            mbuf[1 - mfront][wr_row][wr_plane] = wr_data;
         ack = wrap && swap_req;
         if (ack) mfront = 1 - mfront;
         if (t % DIG_DIV == 0) mseg = model_seg(bcd_in, (t / DIG_DIV) % DIGITS);
      end
      dwell = t % SCAN_DIV;
      row   = (t / SCAN_DIV) % ROWS;
      e.row = ROW_W'(row);
      for (int p = 0; p < PLANES; p++)
         for (int c = 0; c < COLS; c++)
            e.col[p*COLS + c] = (dwell < BLANK_CYC) ? 1'b1 : ~mbuf[mfront][row][p][c];
      e.fs  = wrap;
      e.ack = ack;
      e.seg = mseg;
      e.com = ~(DIGITS'(1) << ((t / DIG_DIV) % DIGITS));
      q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("row_sel",     row_sel,     e.row);
         chk("col_n",       col_n,       e.col);
         chk("frame_start", frame_start, e.fs);
         chk("swap_ack",    swap_ack,    e.ack);
         chk("seg_n",       seg_n,       e.seg);
         chk("com_n",       com_n,       e.com);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_write(input int r, input int p, input logic [COLS-1:0] d);
      wr_en = 1'b1; wr_row = ROW_W'(r); wr_plane = 2'(p); wr_data = d;
      @(negedge CLK);
      wr_en = 1'b0;
   endtask

   task automatic do_swap();
      bit found = 0;
      swap_req = 1'b1;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         @(negedge CLK);
         if (swap_ack === 1'b1) found = 1;
      end
      swap_req = 1'b0;
      chk("swap_ack_seen", 32'(found), 1);
   endtask

   task automatic wait_fs();
      bit found = 0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         @(negedge CLK);
         if (frame_start === 1'b1) found = 1;
      end
      chk("frame_start_seen", 32'(found), 1);
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      #2 reset = 1'b0;
      #1;
      chk("rst_seg_n",   seg_n,       7'b1111111);
      chk("rst_com_n",   com_n,       4'b1110);
      chk("rst_col_n",   col_n,       12'hFFF);
      chk("rst_row_sel", row_sel,     0);
      chk("rst_ack",     swap_ack,    0);
      chk("rst_fs",      frame_start, 0);
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b1;
   endtask

   logic [COLS-1:0] d_se, d_se_n;
   int              n_ack;

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_plane = '0; wr_data = '0;
      swap_req = 1'b0; bcd_in = '0;
      repeat (3) @(negedge CLK);
      reset = 1'b1;

      // Empty buffers: plain scan, frame_start at 16 and 32.
      repeat (40) @(negedge CLK);

      // Write to back buffer, invisible until swapped.
      do_write(2, 1, 4'b0101);
      repeat (2 * FRAME) @(negedge CLK);
      do_swap();
      repeat (FRAME + 4) @(negedge CLK);

      // Held request: one swap per frame boundary.
      wait_fs();
      swap_req = 1'b1;
      n_ack = 0;
      repeat (3 * FRAME) begin
         @(negedge CLK);
         if (swap_ack === 1'b1) n_ack++;
      end
      swap_req = 1'b0;
      chk("held_swap_count", 32'(n_ack), 3);
      repeat (FRAME) @(negedge CLK);

      // Mid-frame reset, then out-of-range writes.
      pulse_reset();
      do_write(5, 0, 4'hF);
      do_write(0, 3, 4'hF);
      do_write(7, 3, 4'hA);
      do_swap();
      repeat (FRAME + 2) @(negedge CLK);

      // Write and swap on the same (wrap) edge.
      wait_fs();
      repeat (FRAME - 1) @(negedge CLK);
      d_se = COLS'($urandom_range(1, 15));
      d_se_n = ~d_se;
      wr_en = 1'b1; wr_row = 3'd0; wr_plane = 2'd2; wr_data = d_se; swap_req = 1'b1;
      @(negedge CLK);
      wr_en = 1'b0; swap_req = 1'b0;
      @(negedge CLK);
      chk("same_edge_visible", 32'(col_n[11:8]), 32'(d_se_n));
      repeat (FRAME) @(negedge CLK);

      // 7-segment patterns and a reset in the middle.
      bcd_in = 16'h0047;
      repeat (16) @(negedge CLK);
      bcd_in = 16'h0A00;
      repeat (16) @(negedge CLK);
      pulse_reset();
      bcd_in = 16'h1000;
      repeat (12) @(negedge CLK);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         wr_en    = ($urandom_range(0, 1) == 1);
         wr_row   = ROW_W'($urandom_range(0, 7));
         wr_plane = 2'($urandom_range(0, 3));
         wr_data  = COLS'($urandom);
         swap_req = ($urandom_range(0, 3) == 0);
         if (i % 8 == 0)
            for (int d = 0; d < DIGITS; d++)
               bcd_in[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
         if (i == 200) begin
            wr_en = 1'b0; swap_req = 1'b0;
            pulse_reset();
         end
         @(negedge CLK);
      end
      wr_en = 1'b0; swap_req = 1'b0;
      repeat (4) @(negedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
